// File: rtl/pwm_compare_stage.sv
// PWM compare stage: double-buffered duty swapped at count wrap, period pulse/tally, held irq; 1-cycle latency, no backpressure.
// Optional count-sequence checker enabled by defining COUNT_CHECK_EN; otherwise err is tied low.
module pwm_compare_stage #(
   parameter int WIDTH  = 8,
   parameter int PCNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WIDTH-1:0]  count,
   input  logic              duty_wr,
   input  logic [WIDTH-1:0]  duty_in,
   input  logic              irq_ack,
   output logic              pwm_out,
   output logic [WIDTH-1:0]  duty_active,
   output logic              period_pulse,
   output logic [PCNT_W-1:0] period_count,
   output logic              irq,
   output logic              err
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] duty_pending;
   logic             pend_flag;
   logic             wrap;

   // A fall to zero from any non-zero value is a period boundary, including an upstream restart.
   assign wrap = (count == '0) && (count_q != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count;
      end
   end

   // A write on the wrap cycle lands in the pending slot after the old pending value moves out.
   always_ff @(posedge clock) begin
      if (reset) begin
         duty_pending <= '0;
         pend_flag    <= 1'b0;
         duty_active  <= '0;
      end else begin
         if (wrap && pend_flag) begin
            duty_active <= duty_pending;
         end
         if (duty_wr) begin
            duty_pending <= duty_in;
            pend_flag    <= 1'b1;
         end else if (wrap) begin
            pend_flag    <= 1'b0;
         end
      end
   end

   // Compare uses the duty held before this edge, so count 0 of a new period still sees the old duty.
   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= (count < duty_active);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         period_pulse <= 1'b0;
         period_count <= '0;
      end else begin
         period_pulse <= wrap;
         if (wrap && (period_count != '1)) begin
            period_count <= period_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         irq <= 1'b0;
      end else if (wrap) begin
         irq <= 1'b1;
      end else if (irq_ack) begin
         irq <= 1'b0;
      end
   end

`ifdef COUNT_CHECK_EN
   logic             chk_valid;
   logic [WIDTH-1:0] count_exp;

   assign count_exp = count_q + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         chk_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         chk_valid <= 1'b1;
         // A jump to zero is an upstream restart, not a sequence fault.
         if (chk_valid && (count != count_exp) && (count != '0)) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Directed bench for pwm_compare_stage driving an 8-bit up-counter model.
module tb_pwm_compare_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  count;
   logic        duty_wr;
   logic [7:0]  duty_in;
   logic        irq_ack;
   logic        pwm_out;
   logic [7:0]  duty_active;
   logic        period_pulse;
   logic [15:0] period_count;
   logic        irq;
   logic        err;

   int n_chk  = 0;
   int n_pass = 0;
   int hi     = 0;
   int pulses = 0;

`ifdef COUNT_CHECK_EN
   localparam logic SEQ_ERR = 1'b1;
`else
   localparam logic SEQ_ERR = 1'b0;
`endif

   pwm_compare_stage #(.WIDTH(8), .PCNT_W(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .count        (count),
      .duty_wr      (duty_wr),
      .duty_in      (duty_in),
      .irq_ack      (irq_ack),
      .pwm_out      (pwm_out),
      .duty_active  (duty_active),
      .period_pulse (period_pulse),
      .period_count (period_count),
      .irq          (irq),
      .err          (err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // DUT samples the current count at the edge, then the counter model advances.
   task automatic tick();
      @(posedge clock);
      #1;
      hi     += int'(pwm_out);
      pulses += int'(period_pulse);
      count  = count + 8'd1;
   endtask

   task automatic write_duty(input logic [7:0] v);
      duty_wr = 1'b1;
      duty_in = v;
      tick();
      duty_wr = 1'b0;
   endtask

   task automatic run_to(input logic [7:0] v);
      while (count != v) tick();
   endtask

   initial begin
      reset   = 1'b1;
      count   = '0;
      duty_wr = 1'b0;
      duty_in = '0;
      irq_ack = 1'b0;

      // 1. reset with random inputs
      for (int i = 0; i < 3; i++) begin
         count   = 8'($urandom);
         duty_wr = 1'($urandom);
         duty_in = 8'($urandom);
         irq_ack = 1'($urandom);
         @(posedge clock);
         #1;
      end
      check("rst_pwm",    32'(pwm_out),      0);
      check("rst_duty",   32'(duty_active),  0);
      check("rst_pulse",  32'(period_pulse), 0);
      check("rst_pcnt",   32'(period_count), 0);
      check("rst_irq",    32'(irq),          0);
      check("rst_err",    32'(err),          0);

      reset   = 1'b0;
      count   = 8'd0;
      duty_wr = 1'b0;
      duty_in = '0;
      irq_ack = 1'b0;
      tick();
      check("first0_pulse", 32'(period_pulse), 0);
      check("first0_irq",   32'(irq),          0);

      // 2. duty 64 written mid-period, active only after wrap
      run_to(8'd10);
      write_duty(8'd64);
      check("pend_duty", 32'(duty_active), 0);
      run_to(8'd0);
      check("pre_wrap_duty", 32'(duty_active), 0);
      check("pre_wrap_pcnt", 32'(period_count), 0);
      pulses = 0;
      tick();
      check("wrap1_pulse", 32'(period_pulse), 1);
      check("wrap1_duty",  32'(duty_active),  64);
      check("wrap1_pwm",   32'(pwm_out),      0);
      check("wrap1_pcnt",  32'(period_count), 1);
      check("wrap1_irq",   32'(irq),          1);

      // 4. ack three cycles after wrap
      hi = 0;
      tick();
      tick();
      check("irq_held", 32'(irq), 1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("irq_acked", 32'(irq), 0);
      tick();
      check("irq_idle_ack", 32'(irq), 0);
      run_to(8'd0);
      tick();
      check("duty64_high", 32'(hi), 64);
      check("wrap2_pcnt",  32'(period_count), 2);
      check("wrap2_pulses", 32'(pulses), 2);
      check("wrap2_irq",   32'(irq), 1);

      // 3. duty 0, with ack coincident with wrap
      write_duty(8'd0);
      run_to(8'd0);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("ack_wrap_irq", 32'(irq), 1);
      check("duty0_active", 32'(duty_active), 0);
      hi = 0;
      write_duty(8'd255);
      run_to(8'd0);
      tick();
      check("duty0_high",     32'(hi), 0);
      check("duty255_active", 32'(duty_active), 255);
      hi = 0;
      repeat (256) tick();
      check("duty255_high", 32'(hi), 255);
      check("wrap5_pcnt",   32'(period_count), 5);

      // 5. upstream restart 37 -> 0 with same-cycle write
      write_duty(8'd100);
      run_to(8'd37);
      tick();
      count   = 8'd0;
      duty_wr = 1'b1;
      duty_in = 8'd200;
      tick();
      duty_wr = 1'b0;
      check("restart_pulse", 32'(period_pulse), 1);
      check("restart_duty",  32'(duty_active),  100);
      check("restart_pcnt",  32'(period_count), 6);
      check("restart_err",   32'(err),          0);
      run_to(8'd0);
      tick();
      check("pending200", 32'(duty_active), 200);

      // hold at zero: single wrap only
      repeat (3) begin
         count = 8'd0;
         tick();
      end
      check("hold0_pulse", 32'(period_pulse), 0);
      check("hold0_pcnt",  32'(period_count), 7);

      // back-to-back writes, last wins
      write_duty(8'd10);
      write_duty(8'd20);
      run_to(8'd0);
      tick();
      check("b2b_duty", 32'(duty_active), 20);
      check("seq_ok_err", 32'(err), 0);

      // 6. sequence 5, 6, 9
      run_to(8'd5);
      tick();
      tick();
      count = 8'd9;
      tick();
      check("seq_err", 32'(err), 32'(SEQ_ERR));
      repeat (4) tick();
      check("seq_err_sticky", 32'(err), 32'(SEQ_ERR));

      // reset mid-operation discards pending duty
      write_duty(8'd77);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2_duty", 32'(duty_active),  0);
      check("rst2_pcnt", 32'(period_count), 0);
      check("rst2_err",  32'(err),          0);
      check("rst2_irq",  32'(irq),          0);
      run_to(8'd0);
      tick();
      check("rst2_wrap_pcnt", 32'(period_count), 1);
      check("rst2_lost_duty", 32'(duty_active),  0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
